// File: rtl/jstk_pkg.sv
// Shared constants, FSM encoding and frame builder for the PmodJSTK SPI responder.
// The frame is 40 bits, sent MSB first, byte 0 in the top bits.
package jstk_pkg;

   localparam int         JSTK_FRAME_BITS     = 40;
   localparam int         JSTK_BYTE_BITS      = 8;
   localparam logic [5:0] JSTK_LED_CMD_PREFIX = 6'b100000;

   localparam int JSTK_BYTE_X_LO = 0;
   localparam int JSTK_BYTE_X_HI = 1;
   localparam int JSTK_BYTE_Y_LO = 2;
   localparam int JSTK_BYTE_Y_HI = 3;
   localparam int JSTK_BYTE_BTN  = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2
   } jstkState_e;

   function automatic logic [JSTK_FRAME_BITS-1:0] buildFrame(
      input logic [9:0] x,
      input logic [9:0] y,
      input logic [2:0] b
   );
      logic [JSTK_FRAME_BITS-1:0] f;
      f = '0;
      f[JSTK_FRAME_BITS-1-JSTK_BYTE_BITS*JSTK_BYTE_X_LO -: JSTK_BYTE_BITS] = x[7:0];
      f[JSTK_FRAME_BITS-1-JSTK_BYTE_BITS*JSTK_BYTE_X_HI -: JSTK_BYTE_BITS] = {6'b0, x[9:8]};
      f[JSTK_FRAME_BITS-1-JSTK_BYTE_BITS*JSTK_BYTE_Y_LO -: JSTK_BYTE_BITS] = y[7:0];
      f[JSTK_FRAME_BITS-1-JSTK_BYTE_BITS*JSTK_BYTE_Y_HI -: JSTK_BYTE_BITS] = {6'b0, y[9:8]};
      f[JSTK_FRAME_BITS-1-JSTK_BYTE_BITS*JSTK_BYTE_BTN  -: JSTK_BYTE_BITS] = {5'b0, b};
      return f;
   endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, followed by an edge-detect
// register producing one-cycle rise/fall strobes in the clk domain.
module spi_in_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic pin_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Left unreset on purpose: a reset mid-frame must not fabricate an SS edge.
   always_ff @(posedge clk) begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      prev_q <= sync_q[SYNC_STAGES-1];
   end

   assign level_o = sync_q[SYNC_STAGES-1];
   assign rise_o  =  sync_q[SYNC_STAGES-1] & ~prev_q;
   assign fall_o  = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule

// File: rtl/jstk_spi_slave.sv
// PmodJSTK joystick emulator: SPI mode-0 responder oversampled in the clk domain.
// Optional macro JSTK_SLV_FRAME_ERR_EN enables frame_err pulses and the err_count output.
module jstk_spi_slave
   import jstk_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int NUM_BYTES   = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ss_n,
   input  logic       sclk,
   input  logic       mosi,
   output logic       miso,
   input  logic [9:0] pos_x,
   input  logic [9:0] pos_y,
   input  logic [2:0] btn,
   output logic [1:0] led,
   output logic       cmd_valid,
   output logic [7:0] cmd_byte,
   output logic       frame_done,
   output logic       frame_err
`ifdef JSTK_SLV_FRAME_ERR_EN
   ,
   output logic [7:0] err_count
`endif
);

   localparam int         FRAME_BITS = NUM_BYTES * JSTK_BYTE_BITS;
   localparam logic [5:0] LAST_BIT   = 6'(FRAME_BITS - 1);
   localparam logic [5:0] FULL_CNT   = 6'(FRAME_BITS);
   localparam logic [5:0] CMD_LAST   = 6'(JSTK_BYTE_BITS - 1);

   logic ssRise, ssFall, sclkRise, sclkFall, mosiSync;
   logic unusedSsLevel, unusedSclkLevel, unusedMosiRise, unusedMosiFall;

   spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) uSsSync (
      .clk(clk), .pin_i(ss_n), .level_o(unusedSsLevel), .rise_o(ssRise), .fall_o(ssFall));
   spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) uSclkSync (
      .clk(clk), .pin_i(sclk), .level_o(unusedSclkLevel), .rise_o(sclkRise), .fall_o(sclkFall));
   spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) uMosiSync (
      .clk(clk), .pin_i(mosi), .level_o(mosiSync), .rise_o(unusedMosiRise), .fall_o(unusedMosiFall));

   jstkState_e                 state_q, state_d;
   logic [JSTK_FRAME_BITS-1:0] txShift_q, txShift_d;
   logic [7:0]                 rx_q, rx_d;
   logic [5:0]                 bitCnt_q, bitCnt_d;
   logic                       cmdLoad_q, cmdLoad_d;
   logic                       cmdValid_q, frameDone_q;
   logic [7:0]                 cmdByte_q;
   logic [1:0]                 led_q;
   logic                       loadFrame, shiftIn, shiftOut, frameDoneSet, frameErrSet;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // An SS edge always takes priority over an SCLK edge in the same cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (ssFall) state_d = ACTIVE;
         ACTIVE:  if (ssRise) state_d = IDLE;
                  else if (sclkRise && bitCnt_q == LAST_BIT) state_d = DONE;
         DONE:    if (ssRise) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      miso         = (state_q == ACTIVE) ? txShift_q[JSTK_FRAME_BITS-1] : 1'b0;
      loadFrame    = (state_q == IDLE)   && ssFall;
      shiftIn      = (state_q == ACTIVE) && !ssRise && sclkRise;
      shiftOut     = (state_q == ACTIVE) && !ssRise && sclkFall;
      frameDoneSet = (state_q == DONE)   && ssRise;
      frameErrSet  = (state_q == ACTIVE) && ssRise;
   end

   always_comb begin
      txShift_d = txShift_q;
      rx_d      = rx_q;
      bitCnt_d  = bitCnt_q;
      cmdLoad_d = 1'b0;
      if (loadFrame) begin
         txShift_d = buildFrame(pos_x, pos_y, btn);
         bitCnt_d  = '0;
      end else if (shiftIn) begin
         rx_d      = {rx_q[6:0], mosiSync};
         cmdLoad_d = (bitCnt_q == CMD_LAST);
         if (bitCnt_q != FULL_CNT) bitCnt_d = bitCnt_q + 6'd1;
      end else if (shiftOut) begin
         txShift_d = {txShift_q[JSTK_FRAME_BITS-2:0], 1'b0};
      end
   end

   // The command byte is committed the cycle after the 8th bit lands in rx_q.
   always_ff @(posedge clk) begin
      if (rst) begin
         txShift_q   <= '0;
         rx_q        <= '0;
         bitCnt_q    <= '0;
         cmdLoad_q   <= 1'b0;
         cmdValid_q  <= 1'b0;
         cmdByte_q   <= '0;
         led_q       <= '0;
         frameDone_q <= 1'b0;
      end else begin
         txShift_q   <= txShift_d;
         rx_q        <= rx_d;
         bitCnt_q    <= bitCnt_d;
         cmdLoad_q   <= cmdLoad_d;
         cmdValid_q  <= cmdLoad_q;
         frameDone_q <= frameDoneSet;
         if (cmdLoad_q) begin
            cmdByte_q <= rx_q;
            if (rx_q[7:2] == JSTK_LED_CMD_PREFIX) led_q <= rx_q[1:0];
         end
      end
   end

   assign led        = led_q;
   assign cmd_valid  = cmdValid_q;
   assign cmd_byte   = cmdByte_q;
   assign frame_done = frameDone_q;

`ifdef JSTK_SLV_FRAME_ERR_EN
   logic       frameErr_q;
   logic [7:0] errCnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         frameErr_q <= 1'b0;
         errCnt_q   <= '0;
      end else begin
         frameErr_q <= frameErrSet;
         if (frameErrSet && errCnt_q != 8'hFF) errCnt_q <= errCnt_q + 8'd1;
      end
   end

   assign frame_err = frameErr_q;
   assign err_count = errCnt_q;
`else
   logic unusedFrameErrSet;
   assign unusedFrameErrSet = frameErrSet;
   assign frame_err         = 1'b0;
`endif

endmodule

// File: doc/jstk_spi_slave.md
Name: jstk_spi_slave

Overview:
- SPI responder emulating the PmodJSTK joystick: answers the existing PmodJSTK SPI master with a 5-byte position/button frame and accepts its LED command byte.
- Used as a bench/board stand-in for the physical joystick and for loopback testing of the stopwatch joystick path.
- Oversamples SS/SCLK/MOSI in the system clock domain; no second clock.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on ss_n/sclk/mosi (must be >= 2)
- NUM_BYTES, 5, frame length in bytes (fixed 5 for PmodJSTK compatibility)

Ports:
- clk  in  1  system clock (100 MHz); must be >= 8x SCLK frequency
- rst  in  1  synchronous, active-high reset
- ss_n  in  1  slave select from master, active low, asynchronous
- sclk  in  1  SPI serial clock, mode 0 (idle low), asynchronous
- mosi  in  1  master out slave in, asynchronous
- miso  out  1  master in slave out, MSB first
- pos_x  in  10  joystick X value to report
- pos_y  in  10  joystick Y value to report
- btn  in  3  button states {btn2, btn1, btn0}
- led  out  2  LED bits from the last valid command byte
- cmd_valid  out  1  one-cycle pulse when a command byte has been received
- cmd_byte  out  8  first byte received in the frame, valid with cmd_valid
- frame_done  out  1  one-cycle pulse when exactly 40 bits completed before SS rises
- frame_err  out  1  one-cycle pulse on a short frame (see Optional Feature)

Behaviour:
- Reset: miso=0, led=2'b00, cmd_valid=0, cmd_byte=8'h00, frame_done=0, frame_err=0, FSM=IDLE, bit counter=0.
- Inputs pass through SYNC_STAGES flops, then one edge-detect register; sclk rise/fall, ss fall/rise are one-cycle strobes.
- Frame format, MSB first, 40-bit tx shift register loaded on the SS falling strobe: byte0=pos_x[7:0], byte1={6'b0,pos_x[9:8]}, byte2=pos_y[7:0], byte3={6'b0,pos_y[9:8]}, byte4={5'b0,btn}. pos_x/pos_y/btn are sampled only at SS fall; later changes do not affect the frame in progress.
- FSM states: IDLE, ACTIVE, DONE.
  - IDLE: miso=0. On SS fall: load snapshot, drive miso=bit39, clear bit counter, go ACTIVE.
  - ACTIVE, sclk rise: shift mosi into 8-bit rx register; increment 6-bit bit counter.
  - ACTIVE, sclk fall: shift tx left and present the next bit on miso.
  - ACTIVE, bit counter reaching 8: cmd_byte<=rx, cmd_valid pulse on the following cycle. If rx[7:2]==6'b100000, led<=rx[1:0]; otherwise led is unchanged.
  - ACTIVE, bit counter reaching 40: go DONE. miso=0 for any further clocks; extra sclk edges are ignored.
  - SS rise in DONE: frame_done pulse, go IDLE.
  - SS rise in ACTIVE: abort, frame_err pulse, go IDLE. A partial command byte (<8 bits) is discarded; led is unchanged.
- Latency: miso updates 3 clk (SYNC_STAGES+1) after the sclk falling pin edge. cmd_valid asserts 4 clk after the 8th sclk rising pin edge.
- Simultaneous sclk and ss edge strobes in one cycle: the ss edge wins; the sclk edge is dropped.
- SS fall while already ACTIVE is impossible by construction (a rise must intervene). rst mid-frame returns to IDLE immediately; no pulses are generated.
- Bit counter saturates at 40; it never wraps.

Optional Feature:
- JSTK_SLV_FRAME_ERR_EN defined:
  - frame_err is generated as described above.
  - An internal 8-bit saturating error counter is exposed on output err_count[7:0]; it resets to 0 on rst.
- Not defined:
  - frame_err is tied 0 and err_count is absent.
  - Short frames silently return to IDLE.

Decomposition:
- Shared package jstk_pkg:
  - JSTK_FRAME_BITS=40
  - JSTK_LED_CMD_PREFIX=6'b100000
  - byte-index constants
  - FSM state encoding (IDLE=2'd0, ACTIVE=2'd1, DONE=2'd2)
- One sub-module: spi_in_sync, the synchroniser plus edge detector, instantiated once per input (ss_n, sclk, mosi).

Test Plan:
- pos_x=10'h2A5, pos_y=10'h13C, btn=3'b101; master sends 8'h83,0,0,0,0 -> MISO bytes A5,02,3C,01,05; led=2'b11; cmd_valid once with cmd_byte=8'h83; frame_done once.
- Command byte 8'h41 -> cmd_valid with cmd_byte=8'h41; led keeps its previous value 2'b11.
- Change pos_x to 10'h3FF after SS fall -> frame still reports A5,02; the next frame reports FF,03.
- SS rises after 17 bits -> frame_err pulse (with JSTK_SLV_FRAME_ERR_EN: err_count=1); no frame_done; next full frame is correct.
- 48 SCLK pulses in one frame -> bytes 0-4 correct, byte 5 reads 8'h00, frame_done once.
- rst asserted at bit 20 -> miso=0, FSM IDLE next cycle, no pulses; led=2'b00.
